cbrt_dispatch: RTL

//  Upstream feeder for the cube-root unit (cbrt). Buffers 8-bit operands in a small FIFO.

---
 rtl/cbrt_dispatch_if.sv | 28 ++
 rtl/cbrt_dispatch.sv | 128 ++++++++++++
 2 files changed

// File: rtl/cbrt_dispatch_if.sv
// cbrt_dispatch_if: bundles the three handshakes of the cube-root dispatcher.
//   in_*   : operand push port (valid/ready, 8-bit operand)
//   cbrt_* : start/busy link to the cube-root unit (8-bit operand, 4-bit root)
//   out_*  : result port (valid/ready, operand + root)
// slave  : dispatcher view; master : environment (feeder, cbrt unit, consumer) view.
interface cbrt_dispatch_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a;
  logic [7:0] cbrt_a;
  logic       cbrt_start;
  logic       cbrt_busy;
  logic [3:0] cbrt_res;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_a;
  logic [3:0] out_root;

  modport slave (
    input  in_valid, in_a, cbrt_busy, cbrt_res, out_ready,
    output in_ready, cbrt_a, cbrt_start, out_valid, out_a, out_root
  );

  modport master (
    output in_valid, in_a, cbrt_busy, cbrt_res, out_ready,
    input  in_ready, cbrt_a, cbrt_start, out_valid, out_a, out_root
  );
endinterface

// File: rtl/cbrt_dispatch.sv
// cbrt_dispatch: feeds 8-bit operands from a small FIFO to a cube-root unit,
// one job at a time, and returns {operand, root} pairs on a valid/ready port.
// A watchdog flags a cube-root unit that never drops busy.
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous active-low reset
//   bus         cbrt_dispatch_if.slave (push port, cbrt link, result port)
//   pending     FIFO occupancy, 0..DEPTH
//   err_timeout sticky watchdog flag, cleared only by reset
module cbrt_dispatch #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned AW      = 2,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  cbrt_dispatch_if.slave       bus,
  output logic [AW:0]          pending,
  output logic                 err_timeout
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_ARM, S_WAIT, S_HOLD} state_t;

  state_t          state_q;
  logic [7:0]      mem_q [DEPTH];
  logic [AW-1:0]   wr_q, rd_q;
  logic [AW:0]     cnt_q, cnt_d;
  logic [CW-1:0]   wd_q;
  logic [7:0]      cbrt_a_q, out_a_q;
  logic [3:0]      out_root_q;
  logic            start_q, out_valid_q, err_q;
  logic            push, pop;

  assign bus.in_ready = (cnt_q != (AW+1)'(DEPTH));
  assign push         = bus.in_valid && bus.in_ready;
  // The head is consumed on the cycle the FSM leaves IDLE.
  assign pop          = (state_q == S_IDLE) && (cnt_q != '0);

  always_comb begin
    cnt_d = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= bus.in_a;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cbrt_a_q    <= '0;
      start_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_a_q     <= '0;
      out_root_q  <= '0;
      err_q       <= 1'b0;
      wd_q        <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (cnt_q != '0) begin
            cbrt_a_q <= mem_q[rd_q];
            start_q  <= 1'b1;
            state_q  <= S_START;
          end
        end
        S_START: begin
          start_q <= 1'b0;
          state_q <= S_ARM;
        end
        S_ARM: begin
          // busy from the cbrt unit lags start by a cycle, so it is not sampled here.
          wd_q    <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (!bus.cbrt_busy) begin
            out_a_q     <= cbrt_a_q;
            out_root_q  <= bus.cbrt_res;
            out_valid_q <= 1'b1;
            state_q     <= S_HOLD;
          end else if (wd_q == CW'(TIMEOUT - 1)) begin
            // TIMEOUT-th busy cycle since WAIT entry: abandon the job.
            err_q   <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end
        S_HOLD: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.cbrt_a     = cbrt_a_q;
  assign bus.cbrt_start = start_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_a      = out_a_q;
  assign bus.out_root   = out_root_q;
  assign pending        = cnt_q;
  assign err_timeout    = err_q;

endmodule
